// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit seven-segment display driver
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_suppress,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PC_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PC_BLANK = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  // All internal values are active-high; INV flips them at the pins.
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [PW-1:0]           r_pc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_sh_value;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic                    r_sh_lz;

  logic                    w_slot_end;
  logic                    w_frame_end;
  logic [3:0]              w_nib;
  logic                    w_dp_req;
  logic                    w_blank_req;
  logic                    w_upper_zero;
  logic                    w_dark;
  logic [6:0]              w_glyph;
  logic [6:0]              w_seg_hi;
  logic                    w_dp_hi;
  logic [NUM_DIGITS-1:0]   w_an_hi;

  assign w_slot_end  = (r_pc == PC_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

  // Prescaler and digit index: the slot advances when the prescaler wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= '0;
      r_idx <= '0;
    end else begin
      r_pc <= w_slot_end ? '0 : r_pc + 1'b1;
      if (w_slot_end) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Shadow copies load only on the last cycle of a frame so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_value <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= '0;
      r_sh_lz    <= 1'b0;
    end else if (w_frame_end) begin
      r_sh_value <= value;
      r_sh_dp    <= dp_in;
      r_sh_blank <= blank;
      r_sh_lz    <= lz_suppress;
    end
  end

  // Select the current digit and work out whether it and every higher digit are zero.
  always_comb begin
    w_nib        = 4'h0;
    w_dp_req     = 1'b0;
    w_blank_req  = 1'b0;
    w_upper_zero = 1'b1;
    w_an_hi      = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k == int'(r_idx)) begin
        w_nib       = r_sh_value[4*k +: 4];
        w_dp_req    = r_sh_dp[k];
        w_blank_req = r_sh_blank[k];
        w_an_hi[k]  = (r_pc >= PC_BLANK);
      end
      if ((k >= int'(r_idx)) && (r_sh_value[4*k +: 4] != 4'h0)) begin
        w_upper_zero = 1'b0;
      end
    end
    w_dark = w_blank_req | (r_sh_lz & (r_idx != '0) & w_upper_zero);
  end

  // Hex glyph table, bit order gfedcba.
  always_comb begin
    w_glyph = 7'h00;
    case (w_nib)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = 7'h77;
      4'hB: w_glyph = 7'h7C;
      4'hC: w_glyph = 7'h39;
      4'hD: w_glyph = 7'h5E;
      4'hE: w_glyph = 7'h79;
      4'hF: w_glyph = 7'h71;
      default: w_glyph = 7'h00;
    endcase
    w_seg_hi = w_dark ? 7'h00 : w_glyph;
    w_dp_hi  = ~w_dark & w_dp_req;
  end

  // Output registers with pin polarity applied; frame_tick stays active-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= {7{INV}};
      dp         <= INV;
      an         <= {NUM_DIGITS{INV}};
      frame_tick <= 1'b0;
    end else begin
      seg        <= w_seg_hi ^ {7{INV}};
      dp         <= w_dp_hi ^ INV;
      an         <= w_an_hi ^ {NUM_DIGITS{INV}};
      frame_tick <= w_frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;
  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BL = 1;
  localparam int F  = N * RD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic        lz = 1'b0;

  logic [6:0] seg_l, seg_h;
  logic       dp_l, dp_h;
  logic [3:0] an_l, an_h;
  logic       tick_l, tick_h;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BL), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .blank(blank),
    .lz_suppress(lz), .seg(seg_l), .dp(dp_l), .an(an_l), .frame_tick(tick_l));

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BL), .ACTIVE_LOW(0)) dut_ah (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .blank(blank),
    .lz_suppress(lz), .seg(seg_h), .dp(dp_h), .an(an_h), .frame_tick(tick_h));

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Segment names lit by each hex code, as letters a..g.
  string glyph_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph(input int v);
    logic [6:0] g;
    string s;
    int b;
    g = 7'h00;
    s = glyph_str[v];
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      g[b - 97] = 1'b1;
    end
    return g;
  endfunction

  // Reference model: position in time since reset decides slot and phase.
  int sh_val [N];
  bit sh_dp [N];
  bit sh_blank [N];
  bit sh_lz;
  int pos, pc, idx;
  bit dark, upz;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [3:0] e_an;
  logic       e_tick;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      pos = 0;
      for (int k = 0; k < N; k++) begin
        sh_val[k] = 0; sh_dp[k] = 1'b0; sh_blank[k] = 1'b0;
      end
      sh_lz = 1'b0;
      e_seg = 7'h00; e_dp = 1'b0; e_an = 4'h0; e_tick = 1'b0;
    end else begin
      pc  = pos % RD;
      idx = (pos / RD) % N;
      dark = sh_blank[idx];
      if (sh_lz && idx != 0) begin
        upz = 1'b1;
        for (int j = idx; j < N; j++) if (sh_val[j] != 0) upz = 1'b0;
        if (upz) dark = 1'b1;
      end
      e_seg  = dark ? 7'h00 : glyph(sh_val[idx]);
      e_dp   = !dark && sh_dp[idx];
      e_an   = (pc >= BL) ? 4'(1 << idx) : 4'h0;
      e_tick = ((pos % F) == F - 1);
      if (e_tick) begin
        for (int k = 0; k < N; k++) begin
          sh_val[k]   = int'(value[4*k +: 4]);
          sh_dp[k]    = dp_in[k];
          sh_blank[k] = blank[k];
        end
        sh_lz = lz;
      end
      pos++;
    end
  end

  // Every-cycle comparison of both polarity builds against the model.
  logic [6:0] i_seg;
  logic [3:0] i_an;
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      i_seg = ~e_seg;
      i_an  = ~e_an;
      check("seg_al", seg_l, i_seg);
      check("dp_al", dp_l, !e_dp);
      check("an_al", an_l, i_an);
      check("tick_al", tick_l, e_tick);
      check("seg_ah", seg_h, e_seg);
      check("dp_ah", dp_h, e_dp);
      check("an_ah", an_h, e_an);
      check("tick_ah", tick_h, e_tick);
      check("an_onehot", ($countones(an_h) <= 1), 1);
    end
  end

  task automatic wait_tick();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4 * F && !found; i++) begin
      @(negedge clk);
      if (tick_l === 1'b1) found = 1'b1;
    end
    check("tick_found", found, 1);
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] exp_an;
  logic [3:0] v4;

  initial begin
    value = 16'hA5C3; dp_in = 4'hF; blank = 4'h0; lz = 1'b0;
    adv(3);
    cmp_en = 1'b1;
    check("rst_seg", seg_l, 7'h7F);
    check("rst_dp", dp_l, 1);
    check("rst_an", an_l, 4'hF);
    check("rst_tick", tick_l, 0);

    // Release; 1234 is captured at the end of the first frame.
    value = 16'h1234; dp_in = 4'h0;
    rst_n = 1'b1;
    adv(1);
    check("rel_an_blank", an_l, 4'hF);
    adv(1);
    check("rel_an_d0", an_l, 4'hE);
    check("rel_seg_zero", seg_l, 7'h40);

    // Scan order with 1234 displayed.
    wait_tick();
    for (int k = 1; k <= F; k++) begin
      adv(1);
      exp_an = ((k - 1) % RD == 0) ? 4'hF : ~(4'(1 << ((k - 1) / RD)));
      check("scan_an", an_l, exp_an);
      check("scan_tick", tick_l, (k == F));
      if (k == 2)  check("scan_d0_4", seg_l, 7'h19);
      if (k == 14) check("scan_d3_1", seg_l, 7'h79);
    end

    // Glyph sweep on digit 0, other fields randomized.
    for (int v = 0; v < 16; v++) begin
      v4 = 4'(v);
      value = {16'($urandom) & 16'hFFF0} | {12'h0, v4};
      dp_in = 4'($urandom);
      blank = 4'($urandom) & 4'hE;
      lz    = 1'($urandom);
      wait_tick();
    end
    repeat (6) begin
      value = 16'($urandom); dp_in = 4'($urandom);
      blank = 4'($urandom); lz = 1'($urandom);
      wait_tick();
    end

    // Leading-zero suppression.
    value = 16'h0050; lz = 1'b1; dp_in = 4'b0100; blank = 4'h0;
    wait_tick();
    wait_tick();
    lz = 1'b0;
    for (int k = 1; k <= F; k++) begin
      adv(1);
      if (k == 14) begin
        check("lz_d3_seg", seg_l, 7'h7F); check("lz_d3_dp", dp_l, 1); check("lz_d3_an", an_l, 4'h7);
      end
      if (k == 10) begin
        check("lz_d2_seg", seg_l, 7'h7F); check("lz_d2_dp", dp_l, 1); check("lz_d2_an", an_l, 4'hB);
      end
      if (k == 6) check("lz_d1_seg", seg_l, 7'h12);
      if (k == 2) check("lz_d0_seg", seg_l, 7'h40);
    end
    adv(10);
    check("nolz_d2_seg", seg_l, 7'h40);
    check("nolz_d2_dp", dp_l, 0);

    // Tear-free capture.
    value = 16'h1111; dp_in = 4'h0; blank = 4'h0; lz = 1'b0;
    wait_tick();
    wait_tick();
    adv(6);
    value = 16'h2222;
    adv(8);
    check("tear_d3_old", seg_l, 7'h79);
    wait_tick();
    adv(14);
    check("tear_d3_new", seg_l, 7'h24);

    // Reset in the slot of digit 2.
    wait_tick();
    value = 16'h8888;
    adv(10);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_seg", seg_l, 7'h7F);
    check("mid_rst_dp", dp_l, 1);
    check("mid_rst_an", an_l, 4'hF);
    check("mid_rst_seg_ah", seg_h, 7'h00);
    check("mid_rst_tick", tick_l, 0);
    adv(3);
    rst_n = 1'b1;
    adv(2);
    check("post_rst_an", an_l, 4'hE);
    check("post_rst_seg", seg_l, 7'h40);
    wait_tick();
    value = 16'($urandom); dp_in = 4'($urandom); lz = 1'b1;
    wait_tick();
    wait_tick();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed N-digit seven-segment display driver, successor to the single-digit hex decoder. It time-multiplexes `NUM_DIGITS` hex nibbles onto one shared segment bus using a programmable refresh prescaler and per-slot anti-ghosting blanking. It also provides per-digit decimal point and blank control, optional leading-zero suppression, and tear-free frame-synchronous input capture. It sits between the datapath (counters, register readback) and the board's display pins.

## Interface
- `NUM_DIGITS`, 4: digits driven; range 1..8.
- `REFRESH_DIV`, 100000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYCLES`, 1000: cycles at the start of each slot with all digit enables inactive; must be < `REFRESH_DIV`.
- `ACTIVE_LOW`, 1: 1 = segment, dp and digit-enable outputs are active-low (common anode); 0 = active-high.
- `clk` input 1: system clock. One clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `value` input 4*NUM_DIGITS: hex nibbles; `value[4k+3:4k]` is digit k; digit 0 is least significant.
- `dp_in` input NUM_DIGITS: decimal point request per digit.
- `blank` input NUM_DIGITS: force digit k fully dark.
- `lz_suppress` input 1: enable leading-zero suppression.
- `seg` output 7: segments, `seg[0]`=a … `seg[6]`=g.
- `dp` output 1: decimal point segment.
- `an` output NUM_DIGITS: digit enables, `an[k]` selects digit k.
- `frame_tick` output 1: one-cycle pulse when a new frame is captured.

## Operation
- State: prescaler `pc` (0..REFRESH_DIV-1), digit index `idx` (0..NUM_DIGITS-1), and shadow registers for `value`, `dp_in`, `blank` and `lz_suppress`.
- `pc` increments every cycle and wraps to 0 after REFRESH_DIV-1. On that wrap, `idx` increments, and wraps from NUM_DIGITS-1 to 0.
- Frame capture: in the cycle where `pc`==REFRESH_DIV-1 and `idx`==NUM_DIGITS-1, all four shadow registers load from the inputs. `frame_tick` is registered and asserts for exactly the next cycle. Input changes at any other time are never visible mid-frame.
- Decode uses the shadow nibble of digit `idx`, which lights these segments:
  - 0:abcdef, 1:bc, 2:abdeg, 3:abcdg, 4:bcfg, 5:acdfg, 6:acdefg, 7:abc
  - 8:abcdefg, 9:abcdfg, A:abcefg, b:cdefg, C:adef, d:bcdeg, E:adefg, F:aefg
- Digit k is dark (seg and dp off, but its slot and `an` timing unchanged) when either condition holds:
  - shadow `blank[k]`=1; or
  - shadow `lz_suppress`=1, k≠0, and shadow nibbles k..NUM_DIGITS-1 are all zero.
- Digit 0 is never zero-suppressed. When not dark, dp follows shadow `dp_in[k]`.
- `an`: one-hot active at `idx` only when `pc` ≥ BLANK_CYCLES; all inactive otherwise.
- Polarity: every active-high internal value is inverted on `seg`, `dp` and `an` when ACTIVE_LOW=1. `frame_tick` is always active-high.

## Timing
- All outputs are registered. Outputs in cycle t+1 reflect `pc`, `idx` and shadow at cycle t (1-cycle latency).
- Reset (async assert, sync-free release):
  - `pc`=0, `idx`=0, shadow all 0 (`lz_suppress` shadow=0).
  - `seg`, `dp` and `an` all inactive; `frame_tick`=0.
- After release: the first frame displays shadow reset content, i.e. "0" on every digit. The first capture occurs after NUM_DIGITS*REFRESH_DIV cycles.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles. `frame_tick` period is identical.
- NUM_DIGITS=1: `idx` stays 0, and a capture happens every `pc` wrap.
- Reset mid-slot or mid-frame: immediate return to reset values. No partial capture survives.
- `an` never has more than one bit active in any cycle, including across slot boundaries.

## Test plan
- Reset: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1; hold `rst_n`=0 with arbitrary clocks -> `seg`=7'h7F, `dp`=1, `an`=4'hF, `frame_tick`=0. Release -> first slot shows `an`=4'hE from the second slot cycle on, with `seg`=7'h40 ("0").
- Scan order and blanking, same params, `value`=16'h1234 captured: per slot, `an` is 4'hF for 1 cycle, then 4'hE/D/B/7 for 3 cycles. Digit 0 shows "4" as `seg`=7'h19; digit 3 shows "1" as `seg`=7'h79. `frame_tick` pulses every 16 cycles.
- Glyph sweep: across frames, load `value` with each of 0..F in digit 0 -> `seg` matches the table for all 16 codes, in both ACTIVE_LOW=1 and ACTIVE_LOW=0 builds (outputs bitwise complementary).
- Leading zero suppression: `value`=16'h0050, `lz_suppress`=1, `dp_in`=4'b0100 -> digits 3 and 2 are dark (`seg`=7'h7F, `dp`=1) with their `an` still strobed. Digit 1 shows `seg`=7'h12, digit 0 shows `seg`=7'h40. With `lz_suppress`=0, digit 2 shows "0" with `dp`=0.
- Tear-free capture: change `value` from 16'h1111 to 16'h2222 during the slot of digit 1 -> digits 1..3 still show "1" for the rest of that frame. All digits show "2" only after the next `frame_tick`.
- Reset mid-frame: assert `rst_n` during the slot of digit 2 -> outputs go inactive asynchronously in the same cycle. After release, scan restarts at digit 0 with shadow 0.
